// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two result FIFOs (ALU, LSB) granted one per cycle onto a registered bus.
// Build option CDB_ARB_FIXED_PRIO_EN: LSB always wins a tie instead of round-robin.
module cdb_arbiter #(
   parameter int ROB_WIDTH   = 4,
   parameter int QUEUE_WIDTH = 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clr_in,

   input  logic                 alu_valid,
   input  logic [ROB_WIDTH-1:0] alu_rob_index,
   input  logic [31:0]          alu_val,
   input  logic                 alu_actual_br,
   input  logic [31:0]          alu_pc_jump,
   output logic                 alu_full,

   input  logic                 lsb_valid,
   input  logic [ROB_WIDTH-1:0] lsb_rob_index,
   input  logic [31:0]          lsb_val,
   output logic                 lsb_full,

   output logic                 cdb_valid,
   output logic                 cdb_src,
   output logic [ROB_WIDTH-1:0] cdb_rob_index,
   output logic [31:0]          cdb_val,
   output logic                 cdb_actual_br,
   output logic [31:0]          cdb_pc_jump
);

   localparam int                     DEPTH    = 2**QUEUE_WIDTH;
   localparam logic [QUEUE_WIDTH:0]   CNT_FULL = (QUEUE_WIDTH+1)'(DEPTH);
   localparam logic [QUEUE_WIDTH:0]   CNT_ONE  = (QUEUE_WIDTH+1)'(1);
   localparam logic [QUEUE_WIDTH-1:0] PTR_ONE  = QUEUE_WIDTH'(1);

   logic [ROB_WIDTH-1:0]   alu_q_rob  [DEPTH];
   logic [31:0]            alu_q_val  [DEPTH];
   logic                   alu_q_br   [DEPTH];
   logic [31:0]            alu_q_jump [DEPTH];
   logic [QUEUE_WIDTH-1:0] alu_head;
   logic [QUEUE_WIDTH-1:0] alu_tail;
   logic [QUEUE_WIDTH:0]   alu_cnt;

   logic [ROB_WIDTH-1:0]   lsb_q_rob  [DEPTH];
   logic [31:0]            lsb_q_val  [DEPTH];
   logic [QUEUE_WIDTH-1:0] lsb_head;
   logic [QUEUE_WIDTH-1:0] lsb_tail;
   logic [QUEUE_WIDTH:0]   lsb_cnt;

   logic alu_ne;
   logic lsb_ne;
   logic grant_alu;
   logic grant_lsb;
   logic alu_push;
   logic lsb_push;
   logic upd_en;

   assign alu_ne   = (alu_cnt != '0);
   assign lsb_ne   = (lsb_cnt != '0);
   assign alu_full = (alu_cnt == CNT_FULL);
   assign lsb_full = (lsb_cnt == CNT_FULL);
   assign upd_en   = rdy_in && !rst_in && !clr_in;

`ifdef CDB_ARB_FIXED_PRIO_EN
   assign grant_lsb = lsb_ne;
`else
   // last_grant = 1 means the LSB was served last, so the ALU wins the next tie
   logic last_grant;

   assign grant_lsb = lsb_ne && (!alu_ne || !last_grant);

   always_ff @(posedge clk_in) begin
      if (rst_in || clr_in) begin
         last_grant <= 1'b1;
      end else if (rdy_in && (grant_alu || grant_lsb)) begin
         last_grant <= grant_lsb;
      end
   end
`endif

   assign grant_alu = alu_ne && !grant_lsb;

   // A full FIFO still takes a push when its head leaves in the same cycle
   assign alu_push = alu_valid && (!alu_full || grant_alu);
   assign lsb_push = lsb_valid && (!lsb_full || grant_lsb);

   always_ff @(posedge clk_in) begin
      if (upd_en) begin
         if (alu_push) begin
            alu_q_rob[alu_tail]  <= alu_rob_index;
            alu_q_val[alu_tail]  <= alu_val;
            alu_q_br[alu_tail]   <= alu_actual_br;
            alu_q_jump[alu_tail] <= alu_pc_jump;
         end
         if (lsb_push) begin
            lsb_q_rob[lsb_tail] <= lsb_rob_index;
            lsb_q_val[lsb_tail] <= lsb_val;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || clr_in) begin
         alu_head      <= '0;
         alu_tail      <= '0;
         alu_cnt       <= '0;
         lsb_head      <= '0;
         lsb_tail      <= '0;
         lsb_cnt       <= '0;
         cdb_valid     <= 1'b0;
         cdb_src       <= 1'b0;
         cdb_rob_index <= '0;
         cdb_val       <= '0;
         cdb_actual_br <= 1'b0;
         cdb_pc_jump   <= '0;
      end else if (rdy_in) begin
         if (alu_push) begin
            alu_tail <= alu_tail + PTR_ONE;
         end
         if (grant_alu) begin
            alu_head <= alu_head + PTR_ONE;
         end
         if (alu_push && !grant_alu) begin
            alu_cnt <= alu_cnt + CNT_ONE;
         end else if (!alu_push && grant_alu) begin
            alu_cnt <= alu_cnt - CNT_ONE;
         end

         if (lsb_push) begin
            lsb_tail <= lsb_tail + PTR_ONE;
         end
         if (grant_lsb) begin
            lsb_head <= lsb_head + PTR_ONE;
         end
         if (lsb_push && !grant_lsb) begin
            lsb_cnt <= lsb_cnt + CNT_ONE;
         end else if (!lsb_push && grant_lsb) begin
            lsb_cnt <= lsb_cnt - CNT_ONE;
         end

         if (grant_alu) begin
            cdb_valid     <= 1'b1;
            cdb_src       <= 1'b0;
            cdb_rob_index <= alu_q_rob[alu_head];
            cdb_val       <= alu_q_val[alu_head];
            cdb_actual_br <= alu_q_br[alu_head];
            cdb_pc_jump   <= alu_q_jump[alu_head];
         end else if (grant_lsb) begin
            cdb_valid     <= 1'b1;
            cdb_src       <= 1'b1;
            cdb_rob_index <= lsb_q_rob[lsb_head];
            cdb_val       <= lsb_q_val[lsb_head];
            cdb_actual_br <= 1'b0;
            cdb_pc_jump   <= '0;
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts queued with stimulus, popped on each new CDB grant.
module tb_cdb_arbiter;
   localparam int RW = 4;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          rdy_in = 1'b1;
   logic          clr_in = 1'b0;
   logic          alu_valid = 1'b0;
   logic [RW-1:0] alu_rob_index = '0;
   logic [31:0]   alu_val = '0;
   logic          alu_actual_br = 1'b0;
   logic [31:0]   alu_pc_jump = '0;
   logic          alu_full;
   logic          lsb_valid = 1'b0;
   logic [RW-1:0] lsb_rob_index = '0;
   logic [31:0]   lsb_val = '0;
   logic          lsb_full;
   logic          cdb_valid;
   logic          cdb_src;
   logic [RW-1:0] cdb_rob_index;
   logic [31:0]   cdb_val;
   logic          cdb_actual_br;
   logic [31:0]   cdb_pc_jump;

   typedef struct {
      logic          src;
      logic [RW-1:0] tag;
      logic [31:0]   val;
      logic          br;
      logic [31:0]   jump;
   } exp_t;

   exp_t sb_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   cdb_arbiter #(.ROB_WIDTH(RW), .QUEUE_WIDTH(1)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .clr_in        (clr_in),
      .alu_valid     (alu_valid),
      .alu_rob_index (alu_rob_index),
      .alu_val       (alu_val),
      .alu_actual_br (alu_actual_br),
      .alu_pc_jump   (alu_pc_jump),
      .alu_full      (alu_full),
      .lsb_valid     (lsb_valid),
      .lsb_rob_index (lsb_rob_index),
      .lsb_val       (lsb_val),
      .lsb_full      (lsb_full),
      .cdb_valid     (cdb_valid),
      .cdb_src       (cdb_src),
      .cdb_rob_index (cdb_rob_index),
      .cdb_val       (cdb_val),
      .cdb_actual_br (cdb_actual_br),
      .cdb_pc_jump   (cdb_pc_jump)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] alu_v(input logic [RW-1:0] t);
      return 32'h0000_0100 + 32'(t);
   endfunction

   function automatic logic [31:0] alu_j(input logic [RW-1:0] t);
      return 32'h0000_2000 + (32'(t) << 2);
   endfunction

   function automatic logic [31:0] lsb_v(input logic [RW-1:0] t);
      return 32'hA000_0000 + 32'(t);
   endfunction

   task automatic drive_alu(input logic v, input logic [RW-1:0] t);
      alu_valid     = v;
      alu_rob_index = t;
      alu_val       = alu_v(t);
      alu_actual_br = t[0];
      alu_pc_jump   = alu_j(t);
   endtask

   task automatic drive_lsb(input logic v, input logic [RW-1:0] t);
      lsb_valid     = v;
      lsb_rob_index = t;
      lsb_val       = lsb_v(t);
   endtask

   task automatic exp_alu(input logic [RW-1:0] t);
      sb_q.push_back('{1'b0, t, alu_v(t), t[0], alu_j(t)});
   endtask

   task automatic exp_lsb(input logic [RW-1:0] t);
      sb_q.push_back('{1'b1, t, lsb_v(t), 1'b0, 32'h0});
   endtask

   // A new broadcast exists only after an edge where the bus registers could update
   always @(posedge clk_in) begin : monitor
      logic upd;
      exp_t e;
      upd = rdy_in && !rst_in && !clr_in;
      #1;
      if (upd && cdb_valid) begin
         tests_run++;
         if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL cdb_unexpected: got src=%0d tag=%0d val=%h, required no broadcast",
                     cdb_src, cdb_rob_index, cdb_val);
         end else begin
            e = sb_q.pop_front();
            if (cdb_src !== e.src || cdb_rob_index !== e.tag || cdb_val !== e.val ||
                cdb_actual_br !== e.br || cdb_pc_jump !== e.jump) begin
               tests_failed++;
               $display("FAIL cdb_data: got src=%0d tag=%0d val=%h br=%0d jump=%h, required src=%0d tag=%0d val=%h br=%0d jump=%h",
                        cdb_src, cdb_rob_index, cdb_val, cdb_actual_br, cdb_pc_jump,
                        e.src, e.tag, e.val, e.br, e.jump);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b1;
      rdy_in = 1'b1;
      clr_in = 1'b0;
      drive_alu(1'b0, '0);
      drive_lsb(1'b0, '0);
      @(negedge clk_in);
      rst_in = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(posedge clk_in);
         #2;
         n++;
      end
      tests_run++;
      if (sb_q.size() != 0) begin
         tests_failed++;
         $display("FAIL %s_drain: %0d broadcasts still pending, required 0", name, sb_q.size());
         sb_q.delete();
      end
      @(posedge clk_in);
      #2;
      tests_run++;
      if (cdb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_idle: cdb_valid=%0d, required 0", name, cdb_valid);
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      drive_alu(1'b1, 4'd2);
      drive_lsb(1'b1, 4'd4);
      repeat (2) @(posedge clk_in);
      #1;
      tests_run++;
      if ({cdb_valid, cdb_src, cdb_actual_br} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_flags: valid/src/br=%b, required 000", {cdb_valid, cdb_src, cdb_actual_br});
      end
      tests_run++;
      if (cdb_rob_index !== '0 || cdb_val !== '0 || cdb_pc_jump !== '0) begin
         tests_failed++;
         $display("FAIL reset_data: tag=%0d val=%h jump=%h, required 0 0 0", cdb_rob_index, cdb_val, cdb_pc_jump);
      end
      tests_run++;
      if (alu_full !== 1'b0 || lsb_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_full: alu_full=%0d lsb_full=%0d, required 0 0", alu_full, lsb_full);
      end
      @(negedge clk_in);
      rst_in = 1'b0;
      drive_alu(1'b0, '0);
      drive_lsb(1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_in);
         #1;
         tests_run++;
         if (cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_discard: cdb_valid=%0d at cycle %0d, required 0", cdb_valid, i);
         end
      end
   endtask

   task automatic test_single_alu();
      do_reset();
      sb_q.push_back('{1'b0, 4'd3, 32'h0000_0055, 1'b1, 32'h0000_1000});
      @(negedge clk_in);
      alu_valid     = 1'b1;
      alu_rob_index = 4'd3;
      alu_val       = 32'h0000_0055;
      alu_actual_br = 1'b1;
      alu_pc_jump   = 32'h0000_1000;
      @(posedge clk_in);
      #1;
      alu_valid = 1'b0;
      tests_run++;
      if (cdb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_early: cdb_valid=%0d after push edge, required 0", cdb_valid);
      end
      @(posedge clk_in);
      #1;
      tests_run++;
      if (cdb_valid !== 1'b1 || cdb_rob_index !== 4'd3) begin
         tests_failed++;
         $display("FAIL single_pulse: valid=%0d tag=%0d, required 1 3", cdb_valid, cdb_rob_index);
      end
      @(posedge clk_in);
      #1;
      tests_run++;
      if (cdb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_width: cdb_valid=%0d one cycle after pulse, required 0", cdb_valid);
      end
      wait_drain("single");
   endtask

   task automatic test_both_push();
      logic exp_af;
      logic exp_lf;
      do_reset();
`ifdef CDB_ARB_FIXED_PRIO_EN
      for (int t = 9; t <= 14; t++) exp_lsb(RW'(t));
      exp_alu(4'd1);
      exp_alu(4'd2);
      exp_af = 1'b1;
      exp_lf = 1'b0;
`else
      exp_alu(4'd1);  exp_lsb(4'd9);
      exp_alu(4'd2);  exp_lsb(4'd10);
      exp_alu(4'd3);  exp_lsb(4'd11);
      exp_alu(4'd4);  exp_lsb(4'd13);
      exp_alu(4'd6);
      exp_af = 1'b1;
      exp_lf = 1'b1;
`endif
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_in);
         if (k == 4) begin
            tests_run++;
            if (alu_full !== exp_af || lsb_full !== exp_lf) begin
               tests_failed++;
               $display("FAIL both_full: alu_full=%0d lsb_full=%0d, required %0d %0d",
                        alu_full, lsb_full, exp_af, exp_lf);
            end
         end
         drive_alu(1'b1, RW'(k));
         drive_lsb(1'b1, RW'(k + 8));
      end
      @(negedge clk_in);
      drive_alu(1'b0, '0);
      drive_lsb(1'b0, '0);
      wait_drain("both");
      tests_run++;
      if (alu_full !== 1'b0 || lsb_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL both_empty: alu_full=%0d lsb_full=%0d, required 0 0", alu_full, lsb_full);
      end
   endtask

`ifndef CDB_ARB_FIXED_PRIO_EN
   task automatic test_lsb_full();
      do_reset();
      exp_alu(4'd1); exp_lsb(4'd9);
      exp_alu(4'd2); exp_lsb(4'd10);
      exp_alu(4'd3); exp_lsb(4'd11);
      @(negedge clk_in);
      drive_alu(1'b1, 4'd1);
      drive_lsb(1'b1, 4'd9);
      @(negedge clk_in);
      drive_alu(1'b1, 4'd2);
      drive_lsb(1'b1, 4'd10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         tests_run++;
         if (lsb_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL lsbfull_step%0d: lsb_full=%0d, required 1", k, lsb_full);
         end
         if (k == 0) begin
            drive_alu(1'b1, 4'd3);
            drive_lsb(1'b1, 4'd11);
         end else if (k == 1) begin
            drive_alu(1'b0, '0);
            drive_lsb(1'b1, 4'd12);
         end else begin
            drive_lsb(1'b0, '0);
         end
      end
      wait_drain("lsbfull");
   endtask
`endif

   task automatic test_flush();
      do_reset();
`ifdef CDB_ARB_FIXED_PRIO_EN
      exp_lsb(4'd9);
      exp_lsb(4'd10);
`else
      exp_alu(4'd1);
      exp_lsb(4'd9);
`endif
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_in);
         drive_alu(1'b1, RW'(k));
         drive_lsb(1'b1, RW'(k + 8));
      end
      @(negedge clk_in);
      clr_in = 1'b1;
      drive_alu(1'b1, 4'd4);
      drive_lsb(1'b1, 4'd12);
      @(negedge clk_in);
      clr_in = 1'b0;
      drive_alu(1'b0, '0);
      drive_lsb(1'b0, '0);
      tests_run++;
      if (cdb_valid !== 1'b0 || alu_full !== 1'b0 || lsb_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_state: valid=%0d alu_full=%0d lsb_full=%0d, required 0 0 0",
                  cdb_valid, alu_full, lsb_full);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_in);
         #1;
         tests_run++;
         if (cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_quiet: cdb_valid=%0d at cycle %0d, required 0", cdb_valid, i);
         end
      end
      tests_run++;
      if (sb_q.size() != 0) begin
         tests_failed++;
         $display("FAIL flush_pre: %0d broadcasts missing before flush, required 0", sb_q.size());
         sb_q.delete();
      end
      exp_alu(4'd7);
      @(negedge clk_in);
      drive_alu(1'b1, 4'd7);
      @(negedge clk_in);
      drive_alu(1'b0, '0);
      wait_drain("flush");
   endtask

   task automatic test_rdy_hold();
      do_reset();
      exp_alu(4'd5);
      exp_alu(4'd6);
      @(negedge clk_in);
      drive_alu(1'b1, 4'd5);
      @(negedge clk_in);
      drive_alu(1'b1, 4'd6);
      @(negedge clk_in);
      drive_alu(1'b0, '0);
      drive_lsb(1'b1, 4'd15);
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_in);
         #1;
         tests_run++;
         if (cdb_valid !== 1'b1 || cdb_rob_index !== 4'd5 || cdb_val !== alu_v(4'd5) ||
             alu_full !== 1'b0 || lsb_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL rdy_hold%0d: valid=%0d tag=%0d val=%h alu_full=%0d lsb_full=%0d, required 1 5 %h 0 0",
                     i, cdb_valid, cdb_rob_index, cdb_val, alu_full, lsb_full, alu_v(4'd5));
         end
      end
      @(negedge clk_in);
      rdy_in = 1'b1;
      drive_lsb(1'b0, '0);
      @(posedge clk_in);
      #1;
      tests_run++;
      if (cdb_valid !== 1'b1 || cdb_rob_index !== 4'd6) begin
         tests_failed++;
         $display("FAIL rdy_release: valid=%0d tag=%0d, required 1 6", cdb_valid, cdb_rob_index);
      end
      wait_drain("rdy");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_alu();
      test_both_push();
`ifndef CDB_ARB_FIXED_PRIO_EN
      test_lsb_full();
`endif
      test_flush();
      test_rdy_hold();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the reservation-station ALU result port and the load/store-buffer result port. Each producer pushes results into its own small FIFO. Every cycle the arbiter grants at most one FIFO head onto a single registered broadcast bus, which the ROB, reservation station and LSB all snoop. It provides backpressure through per-producer full flags and is emptied on pipeline flush.

## Interface
Parameters:
- ROB_WIDTH, 4, width of ROB index tags (tag 0 reserved as "no dependency").
- QUEUE_WIDTH, 1, log2 of per-producer FIFO depth (depth = 2**QUEUE_WIDTH).

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- rdy_in  input  1  global enable; when low, all state holds.
- clr_in  input  1  flush (branch mispredict), synchronous.
- alu_valid  input  1  RS result push.
- alu_rob_index  input  ROB_WIDTH  tag of ALU result.
- alu_val  input  32  ALU result value.
- alu_actual_br  input  1  resolved branch taken.
- alu_pc_jump  input  32  resolved target.
- alu_full  output  1  ALU FIFO holds `depth` entries (combinational from count).
- lsb_valid  input  1  LSB result push.
- lsb_rob_index  input  ROB_WIDTH  tag of LSB result.
- lsb_val  input  32  load value.
- lsb_full  output  1  LSB FIFO holds `depth` entries.
- cdb_valid  output  1  broadcast valid (registered).
- cdb_src  output  1  0 = ALU, 1 = LSB.
- cdb_rob_index  output  ROB_WIDTH  broadcast tag.
- cdb_val  output  32  broadcast value.
- cdb_actual_br  output  1  taken flag; 0 for LSB grants.
- cdb_pc_jump  output  32  target; 0 for LSB grants.

## Operation
- Per FIFO state: head pointer, tail pointer, count (QUEUE_WIDTH+1 bits). Pointers wrap modulo depth.
- Push accepted when valid && (count < depth || FIFO is popped this cycle). A push while full and not popped is dropped; producers must honour *_full.
- Grant on each enabled cycle:
  - Neither FIFO nonempty: no grant, cdb_valid <= 0.
  - Exactly one FIFO nonempty: that FIFO is granted.
  - Both FIFOs nonempty: the FIFO not named by last_grant wins (round-robin).
- Nonempty is evaluated on pre-edge count, so an entry pushed this cycle cannot be granted this cycle.
- On a grant: the head is registered onto cdb_*, head advances, last_grant <= granted source.
- Simultaneous push and pop on one FIFO: count unchanged, both pointers advance.
- Flush and reset, with the same effect:
  - Both FIFOs empty (pointers and count 0).
  - cdb_valid <= 0, last_grant <= 1, so the ALU wins the first tie.
  - Pushes in the same cycle are discarded.
  - rst_in and clr_in take priority over rdy_in.
- Reset values: cdb_valid 0, cdb_src 0, cdb_rob_index 0, cdb_val 0, cdb_actual_br 0, cdb_pc_jump 0, alu_full 0, lsb_full 0.

## Timing
- Push sampled at edge N; earliest cdb_valid is in the cycle after edge N+1 (two-cycle push-to-broadcast latency).
- cdb_valid is a one-cycle pulse per entry; back-to-back grants give continuous valid.
- Throughput is one broadcast per cycle total. A sustained two-source load alternates ALU/LSB.
- *_full reflects count after the previous edge; a producer seeing full = 0 may push in that cycle.
- rdy_in low: FIFOs, last_grant and all cdb_* registers hold, including cdb_valid. Consumers are also gated by rdy_in.

## Configuration
- CDB_ARB_FIXED_PRIO_EN:
  - Defined: on a tie the LSB always wins. last_grant is not implemented and the ALU FIFO may starve while the LSB FIFO stays nonempty.
  - Undefined: round-robin as specified above.

## Test plan
- Single ALU push (tag 3, val 0x55, br 1, jump 0x1000), then idle:
  - cdb_valid high for exactly one cycle, two cycles after the push.
  - cdb_src 0, tag 3, val 0x55, br 1, jump 0x1000.
- Both producers push every cycle for 6 cycles (ALU tags 1..6, LSB tags 9..14):
  - Broadcast order 1,9,2,10,3,11,...
  - Full flags assert, and dropped pushes never appear on the CDB.
- Fill the LSB FIFO with 2 entries (full = 1) and push a third while full without a pop:
  - Third entry is never broadcast.
  - Push plus pop in the same cycle: entry accepted and count stays 2.
- Queue 2 entries in each FIFO, assert clr_in for one cycle together with a new push:
  - cdb_valid low the next cycle and stays low.
  - Both full flags 0, and the next lone push broadcasts normally.
- Hold rdy_in low for 3 cycles while cdb_valid = 1 with tag 5:
  - Outputs and FIFO contents unchanged.
  - After release, the next queued entry follows.
- With CDB_ARB_FIXED_PRIO_EN defined, run the same stimulus as scenario 2:
  - All LSB tags 9..14 broadcast before any ALU tag after the first cycle in which both FIFOs are nonempty.
